// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I load/store funct3 codes, data-memory FSM states and lane helpers.
package rv32_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Half accesses ignore a[0] so an untrapped misaligned half still hits a legal lane pair.
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
        return sz == 2'b00 ? 4'b0001 << a : sz == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
        return sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: control-side strobes and memory-bus handshake of the data-memory access unit.
interface dmem_access_unit_if;

    logic        req_rd;
    logic        req_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_rd, req_wr, funct3, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
        output busy, done, rdata, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output req_rd, req_wr, funct3, addr, wdata, mem_gnt, mem_rvalid, mem_rdata,
        input  busy, done, rdata, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed byte/half/word of a raw read word and sign- or zero-extends it.
module dmem_load_align (
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    // funct3[2] marks the unsigned variants.
    always_comb begin
        o_data = i_funct3[1] ? i_word
               : i_funct3[0] ? {{16{~i_funct3[2] & w_half[15]}}, w_half}
               : {{24{~i_funct3[2] & w_byte[7]}}, w_byte};
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: RV32I load/store unit bridging the control FSM to a req/gnt/rvalid memory bus.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors instead of truncating the address.
module dmem_access_unit
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               rstn,
    dmem_access_unit_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    logic          r_we;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_req;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [3:0]    r_be;
    logic [CW-1:0] r_cnt;
    logic          w_start;
    logic          w_f3_ok;
    logic          w_legal;
    logic          w_tmo;
    logic [31:0]   w_ld;

    assign w_start = bus.req_wr | bus.req_rd;
    assign w_tmo   = r_cnt == CW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        w_f3_ok = bus.req_wr ? bus.funct3 inside {SB, SH, SW} : bus.funct3 inside {LB, LH, LW, LBU, LHU};
`ifdef DMEM_MISALIGN_TRAP_EN
        w_legal = w_f3_ok && !(bus.funct3[1:0] == 2'b01 && bus.addr[0])
                          && !(bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
`else
        w_legal = w_f3_ok;
`endif
    end

    dmem_load_align u_align (
        .i_funct3  (r_f3),
        .i_addr_lo (r_addr[1:0]),
        .i_word    (bus.mem_rdata),
        .o_data    (w_ld)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (w_start) begin
                    r_we    <= bus.req_wr;
                    r_f3    <= bus.funct3;
                    r_addr  <= bus.addr;
                    r_be    <= byte_en(bus.funct3[1:0], bus.addr[1:0]);
                    r_wdata <= lane_data(bus.funct3[1:0], bus.wdata);
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_req   <= w_legal;
                    r_err   <= ~w_legal;
                    r_done  <= ~w_legal;
                    r_state <= w_legal ? REQ : DONE;
                end
                REQ: if (bus.mem_gnt) begin
                    r_req   <= 1'b0;
                    r_cnt   <= '0;
                    r_done  <= r_we;
                    r_state <= r_we ? DONE : WAIT;
                end else if (w_tmo) begin
                    r_req   <= 1'b0;
                    r_err   <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                WAIT: if (bus.mem_rvalid) begin
                    r_rdata <= w_ld;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else if (w_tmo) begin
                    r_err   <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_be    = r_be;
    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed and randomized load/store transactions against an arithmetic reference model.
module tb_dmem_access_unit;
    import rv32_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_rdata = '0;

    dmem_access_unit_if bus();

    dmem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.req_rd     = 1'b0;
        bus.req_wr     = 1'b0;
        bus.funct3     = '0;
        bus.addr       = '0;
        bus.wdata      = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    // dg: REQ cycles before gnt; dr: WAIT cycles before rvalid; >= TMO means never.
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] word, input int dg, input int dr);
        int          nb, be_i, t_done, t_r, ws, req_last;
        logic        legal, exp_err;
        logic [31:0] ea, mask, val, exp_wd;
        nb    = 1 << int'(f3[1:0]);
        legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (a % nb != 0) legal = 1'b0;
        ea = a;
`else
        ea = a - a % nb;
`endif
        be_i   = ((1 << nb) - 1) << int'(ea[1:0]);
        exp_wd = nb == 1 ? wd[7:0] * 32'h01010101 : nb == 2 ? wd[15:0] * 32'h00010001 : wd;
        mask   = nb >= 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
        val    = (word >> (8 * int'(ea[1:0]))) & mask;
        if (!f3[2] && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
        ws  = 1000;
        t_r = 1000;
        if (!legal) begin
            t_done = 1; req_last = 0; exp_err = 1'b1;
        end else if (dg >= TMO) begin
            t_done = 1 + TMO; req_last = TMO; exp_err = 1'b1;
        end else if (wr) begin
            t_done = 2 + dg; req_last = 1 + dg; exp_err = 1'b0;
        end else begin
            req_last = 1 + dg;
            ws = 2 + dg;
            if (dr >= TMO) begin
                t_done = ws + TMO; exp_err = 1'b1;
            end else begin
                t_r = ws + dr; t_done = t_r + 1; exp_err = 1'b0;
            end
        end
        @(posedge clk); #1;
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.req_wr     = wr;
        bus.req_rd     = !wr || $urandom_range(0, 1) == 1;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.wdata      = wd;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        for (int k = 1; k <= t_done; k++) begin
            @(posedge clk); #1;
            check("busy", 32'(bus.busy), 32'd1);
            check("done", 32'(bus.done), 32'(k == t_done));
            check("mem_req", 32'(bus.mem_req), 32'(k <= req_last));
            if (k == 1 && legal) begin
                check("mem_we", 32'(bus.mem_we), 32'(wr));
                check("mem_be", 32'(bus.mem_be), be_i);
                check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
                check("mem_wdata", bus.mem_wdata, exp_wd);
            end
            if (k == t_done) begin
                check("err", 32'(bus.err), 32'(exp_err));
                if (!wr && !exp_err) m_rdata = val;
                check("rdata", bus.rdata, m_rdata);
            end
            bus.req_wr     = k < t_done && $urandom_range(0, 1) == 1;
            bus.req_rd     = k < t_done && $urandom_range(0, 1) == 1;
            bus.funct3     = 3'($urandom);
            bus.addr       = $urandom;
            bus.wdata      = $urandom;
            bus.mem_gnt    = legal && k == 1 + dg;
            bus.mem_rvalid = k == t_r || ((k < ws || k >= t_done) && $urandom_range(0, 3) == 0);
            bus.mem_rdata  = k == t_r ? word : $urandom;
        end
    endtask

    // phase 1 resets while in REQ, phase 2 while in WAIT.
    task automatic reset_mid(input int phase);
        @(posedge clk); #1;
        bus.req_rd = 1'b1;
        bus.funct3 = LW;
        bus.addr   = 32'h200;
        @(posedge clk); #1;
        bus.req_rd  = 1'b0;
        bus.mem_gnt = phase == 2;
        if (phase == 2) begin
            @(posedge clk); #1;
            bus.mem_gnt = 1'b0;
        end
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        check("pre_rst_req", 32'(bus.mem_req), 32'(phase == 1));
        rstn = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        m_rdata = '0;
        bus.mem_rvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_done", 32'(bus.done), 32'd0);
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        drive_idle();
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(bus.err), 32'd0);
        check("reset_req", 32'(bus.mem_req), 32'd0);
        check("reset_we", 32'(bus.mem_we), 32'd0);
        check("reset_be", 32'(bus.mem_be), 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_txn(1'b1, SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        run_txn(1'b1, SB, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);
        run_txn(1'b0, LB, 32'h102, 32'h0, 32'h12F4_5678, 0, 0);
        run_txn(1'b0, LBU, 32'h102, 32'h0, 32'h12F4_5678, 0, 0);
        run_txn(1'b0, LW, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 1);
        run_txn(1'b0, LH, 32'h102, 32'h0, 32'h0, 9, 0);
        run_txn(1'b0, LHU, 32'h106, 32'h0, 32'h8765_4321, 1, 9);
        run_txn(1'b0, LH, 32'h106, 32'h0, 32'h8765_4321, TMO - 1, TMO - 1);
        run_txn(1'b1, 3'b100, 32'h104, 32'h1234_5678, 32'h0, 0, 0);
        run_txn(1'b0, 3'b011, 32'h104, 32'h0, 32'h0, 0, 0);
        reset_mid(1);
        run_txn(1'b0, LW, 32'h300, 32'h0, 32'h0BAD_CAFE, 0, 0);
        reset_mid(2);
        run_txn(1'b0, LHU, 32'h302, 32'h0, 32'hBEEF_1234, 2, 0);
        for (int i = 0; i < 200; i++)
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, TMO + 1), $urandom_range(0, TMO + 1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles spent waiting for mem_gnt or mem_rvalid before a bus error is raised.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 req_rd  in  1  load strobe from control FSM.
REQ-005 req_wr  in  1  store strobe from control FSM.
REQ-006 funct3  in  3  RV32I load/store size and sign encoding.
REQ-007 addr  in  32  byte address from ALU.
REQ-008 wdata  in  32  store data (rs2).
REQ-009 busy  out  1  transaction in progress; control FSM stalls while high.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  32  aligned, extended load result.
REQ-012 err  out  1  misaligned, illegal or timeout; qualified by done.
REQ-013 mem_req  out  1  memory request.
REQ-014 mem_we  out  1  1=write, 0=read.
REQ-015 mem_be  out  4  byte enables.
REQ-016 mem_addr  out  32  word-aligned address, bits [1:0]=00.
REQ-017 mem_wdata  out  32  lane-replicated write data.
REQ-018 mem_gnt  in  1  memory accepts request this cycle.
REQ-019 mem_rvalid  in  1  read data valid.
REQ-020 mem_rdata  in  32  raw read word.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, DONE; busy=1 in every state except IDLE.
REQ-022 In IDLE, req_wr or req_rd SHALL capture funct3/addr/wdata and move to REQ; req_wr wins if both are high; strobes in other states are ignored.
REQ-023 At capture, an illegal access (load funct3 not 000/001/010/100/101, store funct3 not 000/001/010, or misaligned per REQ-035) SHALL go directly to DONE with err=1 and never assert mem_req.
REQ-024 In REQ: mem_req=1, mem_be SHALL be 0001<<a (byte), 0011<<a (half) or 1111 (word), where a=addr[1:0]; mem_wdata SHALL be byte x4, half x2 or word; all held stable until mem_gnt.
REQ-025 On mem_gnt in REQ: a store SHALL move to DONE, a load to WAIT; mem_req drops the following cycle.
REQ-026 In WAIT, mem_rvalid SHALL capture the extracted data into rdata and move to DONE; mem_rvalid outside WAIT is ignored.
REQ-027 Extraction: LB/LBU select byte a, sign- or zero-extended; LH/LHU select half addr[1], sign- or zero-extended; LW passes the word.
REQ-028 DONE SHALL assert done for exactly one cycle, then return to IDLE; rdata holds until the next load capture.
REQ-029 The timeout counter SHALL clear on entering REQ or WAIT and increment each cycle there; reaching TIMEOUT_CYCLES SHALL go to DONE with err=1 and rdata unchanged; mem_gnt or mem_rvalid in the same cycle wins.
REQ-030 Minimum latency, strobe in cycle 0: store done in cycle 2 (gnt in cycle 1); load done in cycle 3 (gnt in cycle 1, rvalid in cycle 2).

Reset
REQ-031 rstn low SHALL force state IDLE and zero counter, rdata and all outputs (busy, done, err, mem_req, mem_we, mem_be) asynchronously.
REQ-032 Reset mid-transaction SHALL abandon it with no done pulse; mem_req drops immediately.

Configuration
REQ-033 Macro DMEM_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-034 Undefined: addr[0] is cleared for half accesses and addr[1:0] for word accesses; no misalignment error is raised; illegal funct3 still errors.
REQ-035 Defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL error per REQ-023.

Structure
REQ-036 Shared package rv32_pkg SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state encoding.
REQ-037 Extraction and extension SHALL live in combinational sub-module dmem_load_align.

Verification
REQ-038 SW addr=0x100 wdata=0xDEADBEEF, gnt in cycle 1 -> mem_be=1111, mem_addr=0x100, done in cycle 2, err=0.
REQ-039 SB addr=0x103 wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5.
REQ-040 LB addr=0x102, mem_rdata=0x12F45678 -> rdata=0xFFFFFFF4; LBU at same address -> 0x000000F4.
REQ-041 LW addr=0x101 -> with macro: done and err=1, no mem_req; without macro: mem_addr=0x100, err=0.
REQ-042 LH with gnt never asserted, TIMEOUT_CYCLES=4 -> done and err=1 exactly 4 cycles after entering REQ.
REQ-043 rstn low while in WAIT -> busy, mem_req, done all 0 immediately; next req_rd served normally.
